seg7_scan_driver: RTL and testbench

Output-side IO peripheral sitting directly downstream of the CPU's 24-bit IO write data bus. On an IO write strobe it latches the 24-bit word. It mirrors the word onto 24 LEDs and time-multiplexes it as 6 hex digits onto an 8-digit common-anode seven-segment display. Includes a prescaled scan counter, guard (anti-ghosting) blanking and optional leading-zero suppression.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/hex_to_seg7.sv | 32 +++
 rtl/seg7_scan_driver.sv | 92 +++++++++
 tb/tb_seg7_scan_driver.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seven-segment scan driver.
//   NUM_DIGITS      : number of hex digits scanned (the 24-bit word holds 6 nibbles)
//   SEG_OFF/EN_OFF  : all segments dark / all digit enables off (active low)
//   SEG_HEX_x       : active-low g..a patterns for hex glyphs 0..F (dp excluded)
package seg7_pkg;
   localparam int         NUM_DIGITS = 6;
   localparam logic [7:0] SEG_OFF    = 8'hFF;
   localparam logic [7:0] EN_OFF     = 8'hFF;

   localparam logic [6:0] SEG_HEX_0 = 7'h40;
   localparam logic [6:0] SEG_HEX_1 = 7'h79;
   localparam logic [6:0] SEG_HEX_2 = 7'h24;
   localparam logic [6:0] SEG_HEX_3 = 7'h30;
   localparam logic [6:0] SEG_HEX_4 = 7'h19;
   localparam logic [6:0] SEG_HEX_5 = 7'h12;
   localparam logic [6:0] SEG_HEX_6 = 7'h02;
   localparam logic [6:0] SEG_HEX_7 = 7'h78;
   localparam logic [6:0] SEG_HEX_8 = 7'h00;
   localparam logic [6:0] SEG_HEX_9 = 7'h10;
   localparam logic [6:0] SEG_HEX_A = 7'h08;
   localparam logic [6:0] SEG_HEX_B = 7'h03;
   localparam logic [6:0] SEG_HEX_C = 7'h46;
   localparam logic [6:0] SEG_HEX_D = 7'h21;
   localparam logic [6:0] SEG_HEX_E = 7'h06;
   localparam logic [6:0] SEG_HEX_F = 7'h0E;
endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational nibble to active-low seven-segment decoder.
//   i_hex : 4-bit hex value
//   o_seg : active-low segments g,f,e,d,c,b,a (bit 6..0)
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] i_hex,
   output logic [6:0] o_seg
);
   always_comb begin
      o_seg = SEG_HEX_0;
      case (i_hex)
         4'h0: o_seg = SEG_HEX_0;
         4'h1: o_seg = SEG_HEX_1;
         4'h2: o_seg = SEG_HEX_2;
         4'h3: o_seg = SEG_HEX_3;
         4'h4: o_seg = SEG_HEX_4;
         4'h5: o_seg = SEG_HEX_5;
         4'h6: o_seg = SEG_HEX_6;
         4'h7: o_seg = SEG_HEX_7;
         4'h8: o_seg = SEG_HEX_8;
         4'h9: o_seg = SEG_HEX_9;
         4'hA: o_seg = SEG_HEX_A;
         4'hB: o_seg = SEG_HEX_B;
         4'hC: o_seg = SEG_HEX_C;
         4'hD: o_seg = SEG_HEX_D;
         4'hE: o_seg = SEG_HEX_E;
         4'hF: o_seg = SEG_HEX_F;
         default: o_seg = SEG_HEX_0;
      endcase
   end
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: latches a 24-bit CPU IO write, mirrors it on LEDs and
// scans it as 6 hex digits onto a common-anode seven-segment display.
//   clk      : CPU clock
//   rst      : synchronous active-high reset
//   io_we    : one-cycle IO write strobe
//   io_wdata : 24-bit write data
//   led      : registered mirror of the latched word
//   seg_out  : active-low segments {dp, g..a}, dp always off
//   seg_en   : active-low digit enables, bit 0 = rightmost digit
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int SCAN_DIV = 23000,
   parameter int GUARD    = 2,
   parameter int BLANK_LZ = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        io_we,
   input  logic [23:0] io_wdata,
   output logic [23:0] led,
   output logic [7:0]  seg_out,
   output logic [7:0]  seg_en
);
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [PW-1:0] r_pre;
   logic [2:0]    r_idx;
   logic [23:0]   r_disp;
   logic [23:0]   r_led;
   logic [7:0]    r_seg_en;
   logic [7:0]    r_seg_out;

   logic          w_wrap;
   logic          w_guard;
   logic          w_lz;
   logic [4:0]    w_bit;
   logic [3:0]    w_nib;
   logic [23:0]   w_upper;
   logic [6:0]    w_seg7;

   assign w_wrap  = (r_pre == PW'(SCAN_DIV - 1));
   assign w_guard = (r_pre < PW'(GUARD));
   assign w_bit   = {r_idx, 2'b00};
   assign w_nib   = r_disp[w_bit +: 4];
   // Everything from the current digit upwards; zero means this digit is a
   // leading zero. Digit 0 is excluded so a zero word still shows "0".
   assign w_upper = r_disp >> w_bit;
   assign w_lz    = (BLANK_LZ != 0) && (r_idx != 3'd0) && (w_upper == 24'd0);

   hex_to_seg7 u_dec (
      .i_hex (w_nib),
      .o_seg (w_seg7)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_disp    <= '0;
         r_led     <= '0;
         r_pre     <= '0;
         r_idx     <= '0;
         r_seg_en  <= EN_OFF;
         r_seg_out <= SEG_OFF;
      end else begin
         if (io_we) begin
            r_disp <= io_wdata;
            r_led  <= io_wdata;
         end

         if (w_wrap) begin
            r_pre <= '0;
            r_idx <= (r_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : r_idx + 3'd1;
         end else begin
            r_pre <= r_pre + PW'(1);
         end

         // Guard cycles at the start of each slot keep every digit dark so the
         // previous digit's pattern never ghosts onto the newly enabled one.
         if (w_guard) begin
            r_seg_en  <= EN_OFF;
            r_seg_out <= SEG_OFF;
         end else begin
            r_seg_en  <= ~(8'd1 << r_idx);
            r_seg_out <= w_lz ? SEG_OFF : {1'b1, w_seg7};
         end
      end
   end

   assign led     = r_led;
   assign seg_en  = r_seg_en;
   assign seg_out = r_seg_out;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: drives two instances (leading-zero blanking on/off)
// with the same stimulus and compares every cycle against a time-based model:
// after t cycles since reset the scan sits in slot (t/SCAN_DIV)%6 at offset
// t%SCAN_DIV, and outputs reflect the state one cycle earlier.
module tb_seg7_scan_driver;
   localparam int SD = 4;
   localparam int G  = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        io_we;
   logic [23:0] io_wdata;
   logic [23:0] led_a, led_b;
   logic [7:0]  seg_a, en_a, seg_b, en_b;

   always #5 clk = ~clk;

   seg7_scan_driver #(.SCAN_DIV(SD), .GUARD(G), .BLANK_LZ(1)) u_dut_lz (
      .clk(clk), .rst(rst), .io_we(io_we), .io_wdata(io_wdata),
      .led(led_a), .seg_out(seg_a), .seg_en(en_a)
   );

   seg7_scan_driver #(.SCAN_DIV(SD), .GUARD(G), .BLANK_LZ(0)) u_dut_nolz (
      .clk(clk), .rst(rst), .io_we(io_we), .io_wdata(io_wdata),
      .led(led_b), .seg_out(seg_b), .seg_en(en_b)
   );

   int n_vec = 0;
   int n_bad = 0;

   // Full 8-bit patterns with dp off, glyphs 0..F.
   logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   int          m_t;
   logic [23:0] m_word;

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0d: got %h expected %h", tag, m_t, obs, exp);
      end
   endtask

   // Returns {seg_en, seg_out} for a scan state of t cycles with word w.
   function automatic logic [15:0] model_out(int t, logic [23:0] w, bit lz);
      int          pre;
      int          idx;
      logic [23:0] up;
      logic [7:0]  en;
      logic [7:0]  sg;
      pre = t % SD;
      idx = (t / SD) % 6;
      if (pre < G) return 16'hFFFF;
      up = w >> (4 * idx);
      en = 8'hFF ^ (8'd1 << idx);
      if (lz && idx > 0 && up == 24'd0) sg = 8'hFF;
      else                              sg = seg_tab[up[3:0]];
      return {en, sg};
   endfunction

   task automatic step(input bit r, input bit we, input logic [23:0] d);
      logic [15:0] ea;
      logic [15:0] eb;
      rst      = r;
      io_we    = we;
      io_wdata = d;
      @(posedge clk);
      if (r) begin
         ea     = 16'hFFFF;
         eb     = 16'hFFFF;
         m_t    = 0;
         m_word = 24'd0;
      end else begin
         ea = model_out(m_t, m_word, 1'b1);
         eb = model_out(m_t, m_word, 1'b0);
         if (we) m_word = d;
         m_t++;
      end
      @(negedge clk);
      chk("led_lz",    led_a, m_word);
      chk("led_nolz",  led_b, m_word);
      chk("en_lz",     {16'd0, en_a},  {16'd0, ea[15:8]});
      chk("seg_lz",    {16'd0, seg_a}, {16'd0, ea[7:0]});
      chk("en_nolz",   {16'd0, en_b},  {16'd0, eb[15:8]});
      chk("seg_nolz",  {16'd0, seg_b}, {16'd0, eb[7:0]});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 24'd0);
   endtask

   initial begin
      m_t    = 0;
      m_word = 24'd0;
      rst      = 1'b1;
      io_we    = 1'b0;
      io_wdata = 24'd0;

      // Reset held 3 cycles, then a full period of the zero word.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 24'd0);
      idle(24);

      // Full-period decode of a mixed word.
      step(1'b0, 1'b1, 24'h123456);
      idle(24);

      // Leading zeros.
      step(1'b0, 1'b1, 24'h00000A);
      idle(24);
      step(1'b0, 1'b1, 24'h000000);
      idle(24);

      // Back-to-back writes mid-slot in digit 0.
      while (m_t % 24 != 1) idle(1);
      step(1'b0, 1'b1, 24'h000001);
      step(1'b0, 1'b1, 24'h000002);
      idle(4);

      // Write coincident with the prescaler wrap.
      while (m_t % SD != SD - 1) idle(1);
      step(1'b0, 1'b1, 24'h00ABC0);
      idle(8);

      // Reset (with a competing write) while digit 3 is being scanned.
      step(1'b0, 1'b1, 24'h987654);
      while ((m_t / SD) % 6 != 3) idle(1);
      step(1'b1, 1'b1, 24'hABCDEF);
      idle(30);

      // Random writes, leading-zero-heavy data, occasional resets.
      for (int i = 0; i < 800; i++) begin
         logic [23:0] d;
         bit          we;
         bit          r;
         d  = 24'($urandom_range(0, 24'hFFFFFF)) >> (4 * $urandom_range(0, 6));
         we = ($urandom % 4) == 0;
         r  = ($urandom % 150) == 0;
         step(r, we, d);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
